eth_udp_stack: RTL and testbench
================================

Name: eth_udp_stack

Overview:
- Combined low-latency Ethernet/IPv4/UDP endpoint: one RX path and one TX path sharing a clock and reset.
- RX path: takes the MAC-side 16-bit beat stream (preamble and FCS already removed), checks and strips the 42-byte Eth+IPv4+UDP header, and forwards the UDP payload to the application.
- TX path: generates the 42-byte header from parameters plus per-packet length and checksum, then streams the application payload to the MAC.

Parameters:
- DATA_W, 16, datapath width in bits. Only 16 is supported, so KEEP_W=2 and LEN_W=2.
- SRC_MAC, 48'h02_00_00_00_00_01, local MAC address. Used as TX source and as the RX unicast match.
- DST_MAC, 48'hFF_FF_FF_FF_FF_FF, TX destination MAC.
- SRC_IP, 32'h0A000001, TX source IP.
- DST_IP, 32'h0A000002, TX destination IP.
- SRC_PORT, 16'd1234, TX source UDP port.
- DST_PORT, 16'd1234, TX destination UDP port.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous reset, active-high (asserted = 1), despite the name
- mac_cancel_i  in  1  abort current RX frame
- mac_valid_i  in  1  RX beat valid
- mac_data_i  in  16  RX beat; byte 0 (first on wire) is in [7:0]
- mac_ctrl_v_i  in  1  beat carries control only; ignored as data
- mac_idle_i  in  1  line idle
- mac_start_i  in  1  first header beat of a frame
- mac_term_i  in  1  last beat of a frame
- mac_term_keep_i  in  2  byte-valid mask on the term beat; LSB = byte 0
- app_valid_o  out  1  RX payload beat valid
- app_cancel_o  out  1  RX frame aborted
- app_data_o  out  16  RX payload
- app_len_o  out  2  valid byte count, 1..2
- app_early_v_i  in  1  TX packet request
- app_ready_v_o  out  1  TX payload beat accepted this cycle
- app_cancel_i  in  1  abort TX packet
- app_valid_i  in  1  TX payload beat valid
- app_last_i  in  1  last TX payload beat
- app_data_i  in  16  TX payload, byte 0 in [7:0]
- app_len_i  in  2  valid bytes in the TX beat, 1..2
- app_pkt_len_i  in  16  UDP payload length in bytes
- app_cs_i  in  16  UDP checksum, inserted verbatim
- mac_ready_i  in  1  MAC accepts a TX beat
- mac_valid_o  out  1  TX beat valid
- mac_data_o  out  16  TX beat
- mac_start_o  out  1  first TX header beat
- mac_term_o  out  1  last TX beat
- mac_term_keep_o  out  2  byte mask on the last beat
- mac_cancel_o  out  1  TX abort

Behaviour:
- Reset: all outputs 0, both FSMs to IDLE.
- RX FSM states: IDLE, HDR, PAYLOAD, DROP.
  - Only beats with mac_valid_i=1 and mac_ctrl_v_i=0 are processed.
  - IDLE→HDR on mac_start_i. A 5-bit beat counter runs over header beats 0..20.
  - Header checks:
    - destination MAC equals SRC_MAC or is all-ones
    - ethertype (bytes 12-13, network order) is 0x0800
    - IPv4 version/IHL byte is 0x45
    - protocol byte 23 is 0x11
  - Any check failure goes to DROP. DROP emits no output and exits to IDLE on mac_term_i.
  - After beat 20 the FSM enters PAYLOAD.
- RX outputs:
  - Registered, 1-cycle latency from the input beat.
  - app_len_o = 2 on ordinary payload beats.
  - On the term beat, app_len_o = popcount(mac_term_keep_i). A keep of 0 produces no output beat.
  - Term in PAYLOAD returns the FSM to IDLE.
- RX abort:
  - mac_cancel_i, or mac_term_i during HDR, pulses app_cancel_o for 1 cycle if any payload was already emitted; otherwise the frame is dropped silently.
  - Either case returns the FSM to IDLE.
  - mac_start_i while busy restarts HDR and pulses app_cancel_o if payload was already emitted.
- TX FSM states: IDLE, HDR, PAYLOAD.
  - IDLE: on app_early_v_i, latch app_pkt_len_i and app_cs_i, then go to HDR.
  - HDR emits 21 beats, advancing only when mac_ready_i=1.
  - Header fields:
    - IP total length = pkt_len+28
    - IP id = 0, flags DF (0x4000), TTL 64
    - IP header checksum = one's-complement sum of the 10 header words, folded, then inverted, computed from latched values
    - UDP length = pkt_len+8
    - UDP checksum = latched app_cs_i
  - All multi-byte fields are big-endian on the wire.
  - mac_start_o is asserted with header beat 0.
- TX PAYLOAD:
  - app_ready_v_o = mac_ready_i (combinational).
  - A beat transfers when app_valid_i && app_ready_v_o.
  - mac_data_o = app_data_i, with mac_valid_o and the other control outputs registered.
  - Last beat: mac_term_o=1, mac_term_keep_o = 2'b01 (len 1) or 2'b11 (len 2); the FSM then returns to IDLE.
- TX stall: mac_ready_i=0 freezes TX state and holds all TX outputs.
- TX abort: app_cancel_i in HDR or PAYLOAD pulses mac_cancel_o for 1 cycle, drops mac_valid_o, and returns the FSM to IDLE.
- Simultaneous events: app_early_v_i in a non-IDLE state is ignored. mac_cancel_i has priority over mac_term_i.

Test Plan:
- Reset → every output is 0; idle RX input (mac_idle_i=1) produces no app_valid_o.
- TX, pkt_len=19, mac_ready=1, 9 full beats plus 1-byte last beat → 21 header beats with IP total length 0x002F, UDP length 0x001B, correct IP checksum; 10 payload beats; final mac_term_keep_o=2'b01.
- TX with mac_ready_i toggled every other cycle → identical byte sequence, no beat lost or duplicated.
- RX of a valid 42-byte header plus 4-byte payload, term keep 2'b11 → two app beats with len 2, 1 cycle after each input beat.
- RX with ethertype 0x86DD → no app_valid_o and no app_cancel_o.
- RX cancel after 1 payload beat → app_cancel_o single-cycle pulse; FSM accepts the next frame normally.

Source files
------------

// File: rtl/eth_udp_stack_if.sv
// Bundles the MAC-side and application-side handshake/data signals of eth_udp_stack.
// The slave modport is the stack's view; master is the environment driving it.
interface eth_udp_stack_if;
  // RX: MAC -> stack -> application
  logic        mac_cancel_i;
  logic        mac_valid_i;
  logic [15:0] mac_data_i;
  logic        mac_ctrl_v_i;
  logic        mac_idle_i;
  logic        mac_start_i;
  logic        mac_term_i;
  logic [1:0]  mac_term_keep_i;
  logic        app_valid_o;
  logic        app_cancel_o;
  logic [15:0] app_data_o;
  logic [1:0]  app_len_o;
  // TX: application -> stack -> MAC
  logic        app_early_v_i;
  logic        app_ready_v_o;
  logic        app_cancel_i;
  logic        app_valid_i;
  logic        app_last_i;
  logic [15:0] app_data_i;
  logic [1:0]  app_len_i;
  logic [15:0] app_pkt_len_i;
  logic [15:0] app_cs_i;
  logic        mac_ready_i;
  logic        mac_valid_o;
  logic [15:0] mac_data_o;
  logic        mac_start_o;
  logic        mac_term_o;
  logic [1:0]  mac_term_keep_o;
  logic        mac_cancel_o;

  modport slave (
    input  mac_cancel_i, mac_valid_i, mac_data_i, mac_ctrl_v_i, mac_idle_i, mac_start_i,
           mac_term_i, mac_term_keep_i, app_early_v_i, app_cancel_i, app_valid_i, app_last_i,
           app_data_i, app_len_i, app_pkt_len_i, app_cs_i, mac_ready_i,
    output app_valid_o, app_cancel_o, app_data_o, app_len_o, app_ready_v_o, mac_valid_o,
           mac_data_o, mac_start_o, mac_term_o, mac_term_keep_o, mac_cancel_o
  );

  modport master (
    output mac_cancel_i, mac_valid_i, mac_data_i, mac_ctrl_v_i, mac_idle_i, mac_start_i,
           mac_term_i, mac_term_keep_i, app_early_v_i, app_cancel_i, app_valid_i, app_last_i,
           app_data_i, app_len_i, app_pkt_len_i, app_cs_i, mac_ready_i,
    input  app_valid_o, app_cancel_o, app_data_o, app_len_o, app_ready_v_o, mac_valid_o,
           mac_data_o, mac_start_o, mac_term_o, mac_term_keep_o, mac_cancel_o
  );
endinterface

// File: rtl/eth_udp_stack.sv
// Ethernet/IPv4/UDP endpoint: RX strips and checks the 42-byte header, TX prepends it.
// 16-bit beats, byte 0 of each beat (first on wire) in [7:0].
module eth_udp_stack #(
  parameter int unsigned DATA_W   = 16,
  parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP   = 32'h0A000001,
  parameter logic [31:0] DST_IP   = 32'h0A000002,
  parameter logic [15:0] SRC_PORT = 16'd1234,
  parameter logic [15:0] DST_PORT = 16'd1234
) (
  input logic            clk,
  input logic            nreset,
  eth_udp_stack_if.slave bus
);

  localparam logic [1:0] RX_IDLE    = 2'd0;
  localparam logic [1:0] RX_HDR     = 2'd1;
  localparam logic [1:0] RX_PAYLOAD = 2'd2;
  localparam logic [1:0] RX_DROP    = 2'd3;

  localparam logic [1:0] TX_IDLE    = 2'd0;
  localparam logic [1:0] TX_HDR     = 2'd1;
  localparam logic [1:0] TX_PAYLOAD = 2'd2;

  // Local MAC as it appears in the first three RX beats (byte-swapped per beat)
  localparam logic [15:0] MAC_W0 = {SRC_MAC[39:32], SRC_MAC[47:40]};
  localparam logic [15:0] MAC_W1 = {SRC_MAC[23:16], SRC_MAC[31:24]};
  localparam logic [15:0] MAC_W2 = {SRC_MAC[7:0],   SRC_MAC[15:8]};

  // ---------------------------------------------------------------- RX
  logic [1:0]        rx_state_q, rx_state_d;
  logic [4:0]        rx_cnt_q, rx_cnt_d;
  logic              uc_q, uc_d, bc_q, bc_d, emitted_q, emitted_d;
  logic              rx_valid_q, rx_valid_d, rx_cancel_q, rx_cancel_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [1:0]        rx_len_q, rx_len_d;
  logic              rx_beat, hdr_ok, uc_nxt, bc_nxt;
  logic [4:0]        hdr_idx;
  logic [15:0]       mac_word;
  logic [1:0]        keep_cnt;

  assign rx_beat  = bus.mac_valid_i & ~bus.mac_ctrl_v_i & ~bus.mac_idle_i;
  assign hdr_idx  = bus.mac_start_i ? 5'd0 : rx_cnt_q;
  assign keep_cnt = {1'b0, bus.mac_term_keep_i[0]} + {1'b0, bus.mac_term_keep_i[1]};
  assign mac_word = (hdr_idx == 5'd0) ? MAC_W0 : (hdr_idx == 5'd1) ? MAC_W1 : MAC_W2;
  assign uc_nxt   = ((hdr_idx == 5'd0) | uc_q) & (bus.mac_data_i == mac_word);
  assign bc_nxt   = ((hdr_idx == 5'd0) | bc_q) & (bus.mac_data_i == 16'hFFFF);

  always_comb begin
    case (hdr_idx)
      5'd2:    hdr_ok = uc_nxt | bc_nxt;
      5'd6:    hdr_ok = (bus.mac_data_i == 16'h0008);
      5'd7:    hdr_ok = (bus.mac_data_i[7:0] == 8'h45);
      5'd11:   hdr_ok = (bus.mac_data_i[15:8] == 8'h11);
      default: hdr_ok = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    uc_d        = uc_q;
    bc_d        = bc_q;
    emitted_d   = emitted_q;
    rx_valid_d  = 1'b0;
    rx_cancel_d = 1'b0;
    rx_data_d   = rx_data_q;
    rx_len_d    = rx_len_q;
    if (rx_state_q != RX_IDLE && bus.mac_cancel_i) begin
      rx_cancel_d = emitted_q;
      emitted_d   = 1'b0;
      rx_state_d  = RX_IDLE;
    end else if (rx_beat && bus.mac_start_i) begin
      // Start while busy restarts the header parse of a new frame
      rx_cancel_d = emitted_q;
      emitted_d   = 1'b0;
      uc_d        = uc_nxt;
      bc_d        = bc_nxt;
      rx_cnt_d    = 5'd1;
      if (bus.mac_term_i)  rx_state_d = RX_IDLE;
      else if (!hdr_ok)    rx_state_d = RX_DROP;
      else                 rx_state_d = RX_HDR;
    end else if (rx_beat) begin
      unique case (rx_state_q)
        RX_HDR: begin
          if (bus.mac_term_i) begin
            rx_cancel_d = emitted_q;
            emitted_d   = 1'b0;
            rx_state_d  = RX_IDLE;
          end else if (!hdr_ok) begin
            rx_state_d = RX_DROP;
          end else begin
            uc_d     = uc_nxt;
            bc_d     = bc_nxt;
            rx_cnt_d = rx_cnt_q + 5'd1;
            if (rx_cnt_q == 5'd20) rx_state_d = RX_PAYLOAD;
          end
        end
        RX_PAYLOAD: begin
          rx_data_d = bus.mac_data_i;
          if (bus.mac_term_i) begin
            rx_valid_d = (keep_cnt != 2'd0);
            rx_len_d   = keep_cnt;
            emitted_d  = 1'b0;
            rx_state_d = RX_IDLE;
          end else begin
            rx_valid_d = 1'b1;
            rx_len_d   = 2'd2;
            emitted_d  = 1'b1;
          end
        end
        RX_DROP: if (bus.mac_term_i) rx_state_d = RX_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      uc_q        <= 1'b0;
      bc_q        <= 1'b0;
      emitted_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_cancel_q <= 1'b0;
      rx_data_q   <= '0;
      rx_len_q    <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      uc_q        <= uc_d;
      bc_q        <= bc_d;
      emitted_q   <= emitted_d;
      rx_valid_q  <= rx_valid_d;
      rx_cancel_q <= rx_cancel_d;
      rx_data_q   <= rx_data_d;
      rx_len_q    <= rx_len_d;
    end
  end

  assign bus.app_valid_o  = rx_valid_q;
  assign bus.app_cancel_o = rx_cancel_q;
  assign bus.app_data_o   = rx_data_q;
  assign bus.app_len_o    = rx_len_q;

  // ---------------------------------------------------------------- TX
  logic [1:0]  tx_state_q, tx_state_d;
  logic [4:0]  tx_cnt_q, tx_cnt_d;
  logic [15:0] pkt_len_q, pkt_len_d, cs_q, cs_d;
  logic        tx_valid_q, tx_valid_d, tx_start_q, tx_start_d, tx_term_q, tx_term_d;
  logic        tx_cancel_q, tx_cancel_d;
  logic [1:0]  tx_keep_q, tx_keep_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic [15:0] ip_len, udp_len, ip_cs, be_word;
  logic [19:0] ip_sum;
  logic [16:0] ip_fold;
  logic [15:0] ip_fold2;
  logic        app_ready;

  assign ip_len  = pkt_len_q + 16'd28;
  assign udp_len = pkt_len_q + 16'd8;
  // Zero-valued header words (id, checksum field) drop out of the sum
  assign ip_sum  = 20'h04500 + 20'(ip_len) + 20'h04000 + 20'h04011
                 + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
                 + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
  assign ip_fold  = 17'(ip_sum[15:0]) + 17'(ip_sum[19:16]);
  assign ip_fold2 = ip_fold[15:0] + 16'(ip_fold[16]);
  assign ip_cs    = ~ip_fold2;

  always_comb begin
    case (tx_cnt_q)
      5'd0:    be_word = DST_MAC[47:32];
      5'd1:    be_word = DST_MAC[31:16];
      5'd2:    be_word = DST_MAC[15:0];
      5'd3:    be_word = SRC_MAC[47:32];
      5'd4:    be_word = SRC_MAC[31:16];
      5'd5:    be_word = SRC_MAC[15:0];
      5'd6:    be_word = 16'h0800;
      5'd7:    be_word = 16'h4500;
      5'd8:    be_word = ip_len;
      5'd10:   be_word = 16'h4000;
      5'd11:   be_word = 16'h4011;
      5'd12:   be_word = ip_cs;
      5'd13:   be_word = SRC_IP[31:16];
      5'd14:   be_word = SRC_IP[15:0];
      5'd15:   be_word = DST_IP[31:16];
      5'd16:   be_word = DST_IP[15:0];
      5'd17:   be_word = SRC_PORT;
      5'd18:   be_word = DST_PORT;
      5'd19:   be_word = udp_len;
      5'd20:   be_word = cs_q;
      default: be_word = 16'h0000;
    endcase
  end

  assign app_ready = (tx_state_q == TX_PAYLOAD) & bus.mac_ready_i & ~bus.app_cancel_i;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    pkt_len_d   = pkt_len_q;
    cs_d        = cs_q;
    tx_valid_d  = tx_valid_q;
    tx_start_d  = tx_start_q;
    tx_term_d   = tx_term_q;
    tx_keep_d   = tx_keep_q;
    tx_data_d   = tx_data_q;
    tx_cancel_d = 1'b0;
    if (tx_state_q != TX_IDLE && bus.app_cancel_i) begin
      tx_cancel_d = 1'b1;
      tx_valid_d  = 1'b0;
      tx_start_d  = 1'b0;
      tx_term_d   = 1'b0;
      tx_keep_d   = 2'b00;
      tx_state_d  = TX_IDLE;
    end else begin
      unique case (tx_state_q)
        TX_IDLE: begin
          if (bus.mac_ready_i) begin
            tx_valid_d = 1'b0;
            tx_start_d = 1'b0;
            tx_term_d  = 1'b0;
            tx_keep_d  = 2'b00;
          end
          if (bus.app_early_v_i) begin
            pkt_len_d  = bus.app_pkt_len_i;
            cs_d       = bus.app_cs_i;
            tx_cnt_d   = 5'd0;
            tx_state_d = TX_HDR;
          end
        end
        TX_HDR: if (bus.mac_ready_i) begin
          tx_valid_d = 1'b1;
          tx_data_d  = {be_word[7:0], be_word[15:8]};
          tx_start_d = (tx_cnt_q == 5'd0);
          tx_term_d  = 1'b0;
          tx_keep_d  = 2'b00;
          tx_cnt_d   = tx_cnt_q + 5'd1;
          if (tx_cnt_q == 5'd20) tx_state_d = TX_PAYLOAD;
        end
        TX_PAYLOAD: if (bus.mac_ready_i) begin
          tx_valid_d = bus.app_valid_i;
          tx_start_d = 1'b0;
          tx_term_d  = bus.app_valid_i & bus.app_last_i;
          tx_keep_d  = 2'b00;
          if (bus.app_valid_i) tx_data_d = bus.app_data_i;
          if (bus.app_valid_i && bus.app_last_i) begin
            tx_keep_d  = (bus.app_len_i == 2'd1) ? 2'b01 : 2'b11;
            tx_state_d = TX_IDLE;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      pkt_len_q   <= '0;
      cs_q        <= '0;
      tx_valid_q  <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_term_q   <= 1'b0;
      tx_keep_q   <= 2'b00;
      tx_data_q   <= '0;
      tx_cancel_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      pkt_len_q   <= pkt_len_d;
      cs_q        <= cs_d;
      tx_valid_q  <= tx_valid_d;
      tx_start_q  <= tx_start_d;
      tx_term_q   <= tx_term_d;
      tx_keep_q   <= tx_keep_d;
      tx_data_q   <= tx_data_d;
      tx_cancel_q <= tx_cancel_d;
    end
  end

  assign bus.app_ready_v_o   = app_ready;
  assign bus.mac_valid_o     = tx_valid_q;
  assign bus.mac_data_o      = tx_data_q;
  assign bus.mac_start_o     = tx_start_q;
  assign bus.mac_term_o      = tx_term_q;
  assign bus.mac_term_keep_o = tx_keep_q;
  assign bus.mac_cancel_o    = tx_cancel_q;

endmodule

// File: tb/tb_eth_udp_stack.sv
// Directed bench for eth_udp_stack: TX header/payload tables, RX frame vectors,
// and hand sequences for aborts and restarts.
module tb_eth_udp_stack;
  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  eth_udp_stack_if bus();
  eth_udp_stack dut (.clk(clk), .nreset(nreset), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] in_data;
    logic [1:0]  in_len;
    logic        in_last;
    logic [15:0] exp_data;
    logic        exp_start;
    logic        exp_term;
    logic [1:0]  exp_keep;
  } tx_vec_t;

  typedef struct {
    logic [15:0] dm0, dm1, dm2, et, pr, p0, p1;
    logic [1:0]  keep;
    logic        v0, v1;
    logic [1:0]  len1;
  } rx_vec_t;

  tx_vec_t tx_tab[31];
  rx_vec_t rx_tab[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic run_tx(input bit toggle, input string tag);
    logic [15:0] cd[64];
    logic        cst[64], ctm[64];
    logic [1:0]  ckp[64];
    int cap_n = 0;
    int p = 0;
    int tail = 0;
    bus.app_pkt_len_i = 16'd19;
    bus.app_cs_i      = 16'hBEEF;
    for (int cyc = 0; cyc < 400 && tail < 6; cyc++) begin
      @(negedge clk);
      bus.app_early_v_i = (cyc == 0);
      bus.mac_ready_i   = toggle ? cyc[0] : 1'b1;
      if (p < 10) begin
        bus.app_valid_i = 1'b1;
        bus.app_data_i  = tx_tab[21+p].in_data;
        bus.app_len_i   = tx_tab[21+p].in_len;
        bus.app_last_i  = tx_tab[21+p].in_last;
      end else begin
        bus.app_valid_i = 1'b0;
        bus.app_last_i  = 1'b0;
      end
      #1;
      if (bus.mac_valid_o && bus.mac_ready_i) begin
        if (cap_n < 64) begin
          cd[cap_n]  = bus.mac_data_o;
          cst[cap_n] = bus.mac_start_o;
          ctm[cap_n] = bus.mac_term_o;
          ckp[cap_n] = bus.mac_term_keep_o;
        end
        cap_n++;
      end
      if (bus.app_valid_i && bus.app_ready_v_o) p++;
      if (cap_n >= 31) tail++;
    end
    @(negedge clk);
    bus.app_valid_i = 1'b0;
    bus.app_last_i  = 1'b0;
    bus.mac_ready_i = 1'b1;
    check({tag, "_beat_count"}, cap_n, 31);
    for (int i = 0; i < 31 && i < cap_n; i++)
      check($sformatf("%s_beat%0d", tag, i), {cd[i], cst[i], ctm[i], ckp[i]},
            {tx_tab[i].exp_data, tx_tab[i].exp_start, tx_tab[i].exp_term, tx_tab[i].exp_keep});
  endtask

  task automatic rx_beat(input logic vld, input logic [15:0] d, input logic st, input logic tm,
                         input logic [1:0] kp, input logic cn, output logic ov,
                         output logic [15:0] od, output logic [1:0] ol, output logic oc);
    bus.mac_valid_i     = vld;
    bus.mac_data_i      = d;
    bus.mac_start_i     = st;
    bus.mac_term_i      = tm;
    bus.mac_term_keep_i = kp;
    bus.mac_cancel_i    = cn;
    @(negedge clk);
    ov = bus.app_valid_o;
    od = bus.app_data_o;
    ol = bus.app_len_o;
    oc = bus.app_cancel_o;
    bus.mac_valid_i  = 1'b0;
    bus.mac_start_i  = 1'b0;
    bus.mac_term_i   = 1'b0;
    bus.mac_cancel_i = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] dm0, dm1, dm2, et, pr,
                          output logic any_v, output logic any_c);
    logic [15:0] w;
    logic ov, oc;
    logic [15:0] od;
    logic [1:0] ol;
    any_v = 1'b0;
    any_c = 1'b0;
    for (int i = 0; i < 21; i++) begin
      case (i)
        0: w = dm0;
        1: w = dm1;
        2: w = dm2;
        6: w = et;
        7: w = 16'h0045;
        11: w = pr;
        default: w = 16'h0C00 + 16'(i);
      endcase
      rx_beat(1'b1, w, (i == 0), 1'b0, 2'b00, 1'b0, ov, od, ol, oc);
      any_v |= ov;
      any_c |= oc;
    end
  endtask

  initial begin
    logic ov, oc, av, ac, seen;
    logic [15:0] od;
    logic [1:0] ol;

    // TX table: hand-computed header for pkt_len=19, cs=0xBEEF, then 10 payload beats
    begin
      logic [15:0] hdr[21];
      hdr = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000, 16'h0100, 16'h0008,
              16'h0045, 16'h2F00, 16'h0000, 16'h0040, 16'h1140, 16'hBC26, 16'h000A,
              16'h0100, 16'h000A, 16'h0200, 16'hD204, 16'hD204, 16'h1B00, 16'hEFBE};
      for (int i = 0; i < 21; i++)
        tx_tab[i] = '{16'h0, 2'd0, 1'b0, hdr[i], (i == 0), 1'b0, 2'b00};
      for (int i = 0; i < 9; i++)
        tx_tab[21+i] = '{16'h1100 + 16'(i), 2'd2, 1'b0, 16'h1100 + 16'(i), 1'b0, 1'b0, 2'b00};
      tx_tab[30] = '{16'h55AA, 2'd1, 1'b1, 16'h55AA, 1'b0, 1'b1, 2'b01};
    end

    rx_tab[0] = '{16'h0002, 16'h0000, 16'h0100, 16'h0008, 16'h1140, 16'hA1B2, 16'hC3D4,
                  2'b11, 1'b1, 1'b1, 2'd2};
    rx_tab[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0008, 16'h1140, 16'h1122, 16'h0033,
                  2'b01, 1'b1, 1'b1, 2'd1};
    rx_tab[2] = '{16'h0002, 16'h0000, 16'h0100, 16'hDD86, 16'h1140, 16'h5566, 16'h7788,
                  2'b11, 1'b0, 1'b0, 2'd0};
    rx_tab[3] = '{16'h0002, 16'h0000, 16'h0100, 16'h0008, 16'h1140, 16'h9ABC, 16'hDEF0,
                  2'b00, 1'b1, 1'b0, 2'd0};
    rx_tab[4] = '{16'h0002, 16'h0000, 16'h0200, 16'h0008, 16'h1140, 16'h1357, 16'h2468,
                  2'b11, 1'b0, 1'b0, 2'd0};
    rx_tab[5] = '{16'h0002, 16'h0000, 16'h0100, 16'h0008, 16'h0640, 16'h1357, 16'h2468,
                  2'b11, 1'b0, 1'b0, 2'd0};

    bus.mac_cancel_i = 0; bus.mac_valid_i = 0; bus.mac_data_i = 0; bus.mac_ctrl_v_i = 0;
    bus.mac_idle_i = 0; bus.mac_start_i = 0; bus.mac_term_i = 0; bus.mac_term_keep_i = 0;
    bus.app_early_v_i = 0; bus.app_cancel_i = 0; bus.app_valid_i = 0; bus.app_last_i = 0;
    bus.app_data_i = 0; bus.app_len_i = 0; bus.app_pkt_len_i = 0; bus.app_cs_i = 0;
    bus.mac_ready_i = 0;

    // Reset
    repeat (3) @(negedge clk);
    check("reset_rx_out", {bus.app_valid_o, bus.app_cancel_o, bus.app_data_o, bus.app_len_o}, 0);
    check("reset_tx_out", {bus.app_ready_v_o, bus.mac_valid_o, bus.mac_data_o, bus.mac_start_o,
                           bus.mac_term_o, bus.mac_term_keep_o, bus.mac_cancel_o}, 0);
    nreset = 1'b0;
    bus.mac_idle_i = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= bus.app_valid_o | bus.app_cancel_o;
    end
    check("idle_no_output", seen, 0);
    bus.mac_idle_i = 1'b0;

    // TX: continuous ready, then ready toggling every cycle
    run_tx(1'b0, "tx_ready");
    run_tx(1'b1, "tx_toggle");

    // TX abort in the middle of the header
    bus.app_pkt_len_i = 16'd4;
    bus.app_early_v_i = 1'b1;
    @(negedge clk);
    bus.app_early_v_i = 1'b0;
    repeat (3) @(negedge clk);
    check("tx_mid_valid", bus.mac_valid_o, 1);
    bus.app_cancel_i = 1'b1;
    @(negedge clk);
    bus.app_cancel_i = 1'b0;
    check("tx_cancel_pulse", {bus.mac_cancel_o, bus.mac_valid_o}, 2'b10);
    @(negedge clk);
    check("tx_cancel_single", {bus.mac_cancel_o, bus.mac_valid_o}, 2'b00);

    // RX vectors
    for (int i = 0; i < 6; i++) begin
      send_hdr(rx_tab[i].dm0, rx_tab[i].dm1, rx_tab[i].dm2, rx_tab[i].et, rx_tab[i].pr, av, ac);
      check($sformatf("rx%0d_hdr_quiet", i), {av, ac}, 0);
      rx_beat(1'b1, rx_tab[i].p0, 1'b0, 1'b0, 2'b00, 1'b0, ov, od, ol, oc);
      check($sformatf("rx%0d_pay0", i), {ov, ov ? od : 16'h0, ov ? ol : 2'd0, oc},
            {rx_tab[i].v0, rx_tab[i].v0 ? rx_tab[i].p0 : 16'h0, rx_tab[i].v0 ? 2'd2 : 2'd0, 1'b0});
      rx_beat(1'b1, rx_tab[i].p1, 1'b0, 1'b1, rx_tab[i].keep, 1'b0, ov, od, ol, oc);
      check($sformatf("rx%0d_term", i), {ov, ov ? od : 16'h0, ov ? ol : 2'd0, oc},
            {rx_tab[i].v1, rx_tab[i].v1 ? rx_tab[i].p1 : 16'h0, rx_tab[i].len1, 1'b0});
      rx_beat(1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b0, ov, od, ol, oc);
      check($sformatf("rx%0d_after", i), {ov, oc}, 0);
    end

    // RX cancel after one payload beat, then a normal frame
    send_hdr(16'h0002, 16'h0000, 16'h0100, 16'h0008, 16'h1140, av, ac);
    rx_beat(1'b1, 16'h5A5A, 1'b0, 1'b0, 2'b00, 1'b0, ov, od, ol, oc);
    check("rxc_pay0", {ov, od, ol}, {1'b1, 16'h5A5A, 2'd2});
    rx_beat(1'b0, 16'h0, 1'b0, 1'b1, 2'b11, 1'b1, ov, od, ol, oc);
    check("rxc_cancel_pulse", {ov, oc}, 2'b01);
    rx_beat(1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b0, ov, od, ol, oc);
    check("rxc_cancel_single", {ov, oc}, 2'b00);
    send_hdr(16'h0002, 16'h0000, 16'h0100, 16'h0008, 16'h1140, av, ac);
    rx_beat(1'b1, 16'h0F0F, 1'b0, 1'b1, 2'b11, 1'b0, ov, od, ol, oc);
    check("rxc_next_frame", {av, ac, ov, od, ol, oc}, {2'b00, 1'b1, 16'h0F0F, 2'd2, 1'b0});

    // RX start while in payload: restart with cancel pulse, new frame still delivered
    send_hdr(16'h0002, 16'h0000, 16'h0100, 16'h0008, 16'h1140, av, ac);
    rx_beat(1'b1, 16'h1111, 1'b0, 1'b0, 2'b00, 1'b0, ov, od, ol, oc);
    check("rxr_pay0", {ov, od}, {1'b1, 16'h1111});
    send_hdr(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0008, 16'h1140, av, ac);
    check("rxr_restart_cancel", {av, ac}, 2'b01);
    rx_beat(1'b1, 16'h2222, 1'b0, 1'b1, 2'b11, 1'b0, ov, od, ol, oc);
    check("rxr_new_frame", {ov, od, ol, oc}, {1'b1, 16'h2222, 2'd2, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
